// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, forwarding and halt/drain controller for a 5-stage RV32I pipeline.
// Latency: forwarding and stall/flush controls are combinational; FSM and counters update on clk.
// Backpressure: stalls IF/ID for one cycle on load-use; freezes IF/ID while draining or halted.
module pipeline_hazard_ctrl #(
    parameter int REG_W        = 5,
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] ID_rs1,
    input  logic [REG_W-1:0] ID_rs2,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic [REG_W-1:0] EX_rs1,
    input  logic [REG_W-1:0] EX_rs2,
    input  logic [REG_W-1:0] ID_EX_RD,
    input  logic             ID_EX_regwrite,
    input  logic             ID_EX_wb_sel,
    input  logic [REG_W-1:0] EX_MEM_RD,
    input  logic             EX_MEM_regwrite,
    input  logic             EX_MEM_wb_sel,
    input  logic [REG_W-1:0] MEM_WB_RD,
    input  logic             MEM_WB_regwrite,
    input  logic             PC_sel,
    input  logic             halt_req,
    output logic             stall_if,
    output logic             stall_id,
    output logic             flush_id,
    output logic             flush_ex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halt_ack,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED, RESUME} state_t;

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    state_t        state, state_nxt;
    logic [DW-1:0] drain_cnt, drain_nxt;
    logic          luh;
    logic          stall_if_c, stall_id_c, flush_id_c, flush_ex_c, halt_ack_c;
    logic          stall_inc;
    logic [1:0]    fwd_a_c, fwd_b_c;

    // EX/MEM loads have no ALU result to forward; their consumer is covered by the load-use stall.
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs);
        if (EX_MEM_regwrite && (EX_MEM_RD != '0) && (EX_MEM_RD == rs) && !EX_MEM_wb_sel)
            return 2'b01;
        else if (MEM_WB_regwrite && (MEM_WB_RD != '0) && (MEM_WB_RD == rs))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign fwd_a_c = fwd_sel(EX_rs1);
    assign fwd_b_c = fwd_sel(EX_rs2);

    assign luh = ID_EX_regwrite && ID_EX_wb_sel && (ID_EX_RD != '0) &&
                 ((ID_use_rs1 && (ID_EX_RD == ID_rs1)) || (ID_use_rs2 && (ID_EX_RD == ID_rs2)));

    always_comb begin
        state_nxt  = state;
        drain_nxt  = drain_cnt;
        stall_if_c = 1'b0;
        stall_id_c = 1'b0;
        flush_id_c = 1'b0;
        flush_ex_c = 1'b0;
        halt_ack_c = 1'b0;
        stall_inc  = 1'b0;
        case (state)
            RUN: begin
                if (PC_sel) begin
                    flush_id_c = 1'b1;
                    flush_ex_c = 1'b1;
                end else if (luh) begin
                    stall_if_c = 1'b1;
                    stall_id_c = 1'b1;
                    flush_ex_c = 1'b1;
                    stall_inc  = 1'b1;
                end
                if (halt_req) begin
                    state_nxt = DRAIN;
                    drain_nxt = '0;
                end
            end
            DRAIN: begin
                stall_if_c = 1'b1;
                stall_id_c = 1'b1;
                flush_id_c = 1'b1;
                // A late redirect must still load its target into the PC, so draining starts over.
                if (PC_sel) begin
                    stall_if_c = 1'b0;
                    flush_ex_c = 1'b1;
                end
                if (!halt_req) begin
                    state_nxt = RESUME;
                end else if (PC_sel) begin
                    drain_nxt = '0;
                end else begin
                    drain_nxt = drain_cnt + DW'(1);
                    if (drain_nxt >= DRAIN_LAST)
                        state_nxt = HALTED;
                end
            end
            HALTED: begin
                halt_ack_c = 1'b1;
                stall_if_c = 1'b1;
                stall_id_c = 1'b1;
                flush_id_c = 1'b1;
                if (!halt_req)
                    state_nxt = RESUME;
            end
            RESUME: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    assign stall_if = rst & stall_if_c;
    assign stall_id = rst & stall_id_c;
    assign flush_id = rst & flush_id_c;
    assign flush_ex = rst & flush_ex_c;
    assign halt_ack = rst & halt_ack_c;
    assign fwd_a    = rst ? fwd_a_c : 2'b00;
    assign fwd_b    = rst ? fwd_b_c : 2'b00;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_inc && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
            if (PC_sel && (flush_count != '1))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl with a queue-based scoreboard and negedge monitor.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] ID_rs1, ID_rs2, EX_rs1, EX_rs2, ID_EX_RD, EX_MEM_RD, MEM_WB_RD;
    logic       ID_use_rs1, ID_use_rs2, ID_EX_regwrite, ID_EX_wb_sel;
    logic       EX_MEM_regwrite, EX_MEM_wb_sel, MEM_WB_regwrite, PC_sel, halt_req;
    logic       stall_if, stall_id, flush_id, flush_ex, halt_ack;
    logic [1:0] fwd_a, fwd_b;
    logic [15:0] stall_count, flush_count;

    typedef struct {
        string       nm;
        logic [40:0] v;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    pipeline_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
        .EX_rs1(EX_rs1), .EX_rs2(EX_rs2),
        .ID_EX_RD(ID_EX_RD), .ID_EX_regwrite(ID_EX_regwrite), .ID_EX_wb_sel(ID_EX_wb_sel),
        .EX_MEM_RD(EX_MEM_RD), .EX_MEM_regwrite(EX_MEM_regwrite), .EX_MEM_wb_sel(EX_MEM_wb_sel),
        .MEM_WB_RD(MEM_WB_RD), .MEM_WB_regwrite(MEM_WB_regwrite),
        .PC_sel(PC_sel), .halt_req(halt_req),
        .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id), .flush_ex(flush_ex),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .halt_ack(halt_ack),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // Wait for the next rising edge, then drive a quiet pipeline (rst and halt_req persist).
    task automatic tick();
        @(posedge clk);
        #1;
        ID_rs1 = '0; ID_rs2 = '0; ID_use_rs1 = 0; ID_use_rs2 = 0;
        EX_rs1 = '0; EX_rs2 = '0;
        ID_EX_RD = '0; ID_EX_regwrite = 0; ID_EX_wb_sel = 0;
        EX_MEM_RD = '0; EX_MEM_regwrite = 0; EX_MEM_wb_sel = 0;
        MEM_WB_RD = '0; MEM_WB_regwrite = 0; PC_sel = 0;
    endtask

    task automatic expect_out(input string nm, input logic si, input logic sd, input logic fi,
                              input logic fe, input logic [1:0] fa, input logic [1:0] fb,
                              input logic ack, input logic [15:0] sc, input logic [15:0] fc);
        exp_t e;
        e.nm = nm;
        e.v  = {si, sd, fi, fe, fa, fb, ack, sc, fc};
        q.push_back(e);
    endtask

    task automatic set_luh(input logic [4:0] rd);
        ID_EX_regwrite = 1; ID_EX_wb_sel = 1; ID_EX_RD = rd;
        ID_rs1 = rd; ID_use_rs1 = 1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [40:0] act;
            e   = q.pop_front();
            act = {stall_if, stall_id, flush_id, flush_ex, fwd_a, fwd_b, halt_ack,
                   stall_count, flush_count};
            n_tests++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL %s: got si/sd/fi/fe=%b%b%b%b fa=%b fb=%b ack=%b sc=%h fc=%h, exp %b%b%b%b fa=%b fb=%b ack=%b sc=%h fc=%h",
                         e.nm, act[40], act[39], act[38], act[37], act[36:35], act[34:33], act[32],
                         act[31:16], act[15:0], e.v[40], e.v[39], e.v[38], e.v[37], e.v[36:35],
                         e.v[34:33], e.v[32], e.v[31:16], e.v[15:0]);
            end
        end
    end

    initial begin
        halt_req = 0;
        // Reset: outputs forced low even with a forwarding match present.
        tick(); EX_MEM_regwrite = 1; EX_MEM_RD = 5; EX_rs1 = 5; set_luh(6);
        expect_out("reset", 0,0,0,0, 2'b00,2'b00, 0, 16'd0, 16'd0);
        tick(); rst = 1;

        // Forwarding
        tick(); EX_MEM_regwrite = 1; EX_MEM_RD = 5; EX_rs1 = 5; EX_rs2 = 1;
        expect_out("fwd_exmem", 0,0,0,0, 2'b01,2'b00, 0, 16'd0, 16'd0);
        tick(); MEM_WB_regwrite = 1; MEM_WB_RD = 5; EX_rs1 = 5; EX_rs2 = 5;
        expect_out("fwd_memwb", 0,0,0,0, 2'b10,2'b10, 0, 16'd0, 16'd0);
        tick(); EX_MEM_regwrite = 1; EX_MEM_RD = 5; MEM_WB_regwrite = 1; MEM_WB_RD = 5;
        EX_rs1 = 5; EX_rs2 = 5;
        expect_out("fwd_prio", 0,0,0,0, 2'b01,2'b01, 0, 16'd0, 16'd0);
        tick(); EX_MEM_regwrite = 1; EX_MEM_wb_sel = 1; EX_MEM_RD = 5;
        MEM_WB_regwrite = 1; MEM_WB_RD = 5; EX_rs1 = 5; EX_rs2 = 7;
        expect_out("fwd_load_mem", 0,0,0,0, 2'b10,2'b00, 0, 16'd0, 16'd0);
        tick(); EX_MEM_regwrite = 1; MEM_WB_regwrite = 1;
        expect_out("fwd_x0", 0,0,0,0, 2'b00,2'b00, 0, 16'd0, 16'd0);
        tick(); set_luh(0);
        expect_out("luh_x0", 0,0,0,0, 2'b00,2'b00, 0, 16'd0, 16'd0);

        // Load-use stall and the following forward
        tick(); set_luh(6); ID_rs2 = 1; ID_use_rs2 = 1;
        expect_out("luh_stall", 1,1,0,1, 2'b00,2'b00, 0, 16'd0, 16'd0);
        tick(); EX_MEM_regwrite = 1; EX_MEM_wb_sel = 1; EX_MEM_RD = 6;
        expect_out("luh_bubble", 0,0,0,0, 2'b00,2'b00, 0, 16'd1, 16'd0);
        tick(); MEM_WB_regwrite = 1; MEM_WB_RD = 6; EX_rs1 = 6;
        expect_out("luh_fwd", 0,0,0,0, 2'b10,2'b00, 0, 16'd1, 16'd0);
        tick(); ID_EX_regwrite = 1; ID_EX_wb_sel = 1; ID_EX_RD = 6; ID_rs2 = 6; ID_rs1 = 3;
        ID_use_rs1 = 1;
        expect_out("luh_unused_rs2", 0,0,0,0, 2'b00,2'b00, 0, 16'd1, 16'd0);
        tick(); ID_EX_regwrite = 1; ID_EX_wb_sel = 1; ID_EX_RD = 6; ID_rs2 = 6; ID_use_rs2 = 1;
        expect_out("luh_rs2", 1,1,0,1, 2'b00,2'b00, 0, 16'd1, 16'd0);

        // Redirect beats load-use
        tick(); set_luh(6); PC_sel = 1;
        expect_out("redir_prio", 0,0,1,1, 2'b00,2'b00, 0, 16'd2, 16'd0);
        tick();
        expect_out("redir_cnt", 0,0,0,0, 2'b00,2'b00, 0, 16'd2, 16'd1);

        // Halt, drain, release
        tick(); halt_req = 1;
        expect_out("halt_req_run", 0,0,0,0, 2'b00,2'b00, 0, 16'd2, 16'd1);
        tick(); expect_out("drain1", 1,1,1,0, 2'b00,2'b00, 0, 16'd2, 16'd1);
        tick(); expect_out("drain2", 1,1,1,0, 2'b00,2'b00, 0, 16'd2, 16'd1);
        tick(); set_luh(4);
        expect_out("halted", 1,1,1,0, 2'b00,2'b00, 1, 16'd2, 16'd1);
        tick(); halt_req = 0;
        expect_out("halted_release", 1,1,1,0, 2'b00,2'b00, 1, 16'd2, 16'd1);
        tick(); set_luh(4);
        expect_out("resume", 0,0,0,0, 2'b00,2'b00, 0, 16'd2, 16'd1);
        tick(); set_luh(4);
        expect_out("run_after_resume", 1,1,0,1, 2'b00,2'b00, 0, 16'd2, 16'd1);
        tick(); expect_out("run_idle", 0,0,0,0, 2'b00,2'b00, 0, 16'd3, 16'd1);

        // Redirect during drain restarts the drain
        tick(); halt_req = 1;
        expect_out("halt2_req", 0,0,0,0, 2'b00,2'b00, 0, 16'd3, 16'd1);
        tick(); PC_sel = 1;
        expect_out("drain_redir", 0,1,1,1, 2'b00,2'b00, 0, 16'd3, 16'd1);
        tick(); expect_out("drain_r1", 1,1,1,0, 2'b00,2'b00, 0, 16'd3, 16'd2);
        tick(); expect_out("drain_r2", 1,1,1,0, 2'b00,2'b00, 0, 16'd3, 16'd2);
        tick(); halt_req = 0;
        expect_out("halted2", 1,1,1,0, 2'b00,2'b00, 1, 16'd3, 16'd2);
        tick(); expect_out("resume2", 0,0,0,0, 2'b00,2'b00, 0, 16'd3, 16'd2);

        // Halt abandoned mid-drain
        tick(); halt_req = 1;
        expect_out("halt3_req", 0,0,0,0, 2'b00,2'b00, 0, 16'd3, 16'd2);
        tick(); halt_req = 0;
        expect_out("drain_abandon", 1,1,1,0, 2'b00,2'b00, 0, 16'd3, 16'd2);
        tick(); expect_out("abandon_resume", 0,0,0,0, 2'b00,2'b00, 0, 16'd3, 16'd2);
        tick(); set_luh(9);
        expect_out("abandon_run", 1,1,0,1, 2'b00,2'b00, 0, 16'd3, 16'd2);

        // Asynchronous reset during drain
        tick(); halt_req = 1;
        expect_out("halt4_req", 0,0,0,0, 2'b00,2'b00, 0, 16'd4, 16'd2);
        tick(); expect_out("drain4", 1,1,1,0, 2'b00,2'b00, 0, 16'd4, 16'd2);
        tick(); rst = 0; set_luh(6); EX_MEM_regwrite = 1; EX_MEM_RD = 6; EX_rs1 = 6;
        expect_out("rst_mid_drain", 0,0,0,0, 2'b00,2'b00, 0, 16'd0, 16'd0);
        tick(); rst = 1; halt_req = 0; set_luh(6);
        expect_out("rst_run", 1,1,0,1, 2'b00,2'b00, 0, 16'd0, 16'd0);
        tick(); expect_out("rst_run_cnt", 0,0,0,0, 2'b00,2'b00, 0, 16'd1, 16'd0);

        // Flush counter saturation
        for (int i = 0; i < 65535; i++) begin
            tick(); PC_sel = 1;
        end
        tick(); PC_sel = 1;
        expect_out("flush_at_max", 0,0,1,1, 2'b00,2'b00, 0, 16'd1, 16'hFFFF);
        tick();
        expect_out("flush_saturate", 0,0,0,0, 2'b00,2'b00, 0, 16'd1, 16'hFFFF);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_queue: %0d expectations left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
